// File: rtl/twi_line_conditioner.sv
// Pad-side conditioner for the TWI slave: synchronise and glitch-filter SCL/SDA,
// detect START/STOP and stuck-low bus, and drive open-drain pad enables.
module twi_line_conditioner #(
   parameter int FILTER_LEN = 4,
   parameter int TIMEOUT_W  = 20,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  pad_scl_i,
   input  logic                  pad_sda_i,
   output logic                  pad_scl_oe_o,
   output logic                  pad_sda_oe_o,
   output logic                  core_scl_o,
   output logic                  core_sda_o,
   input  logic                  core_scl_i,
   input  logic                  core_sda_i,
   input  logic                  wren_i,
   input  logic                  rden_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  ack_o,
   output logic                  bus_busy_o,
   output logic                  stuck_o
);

   localparam int FCW = $clog2(FILTER_LEN + 1);

   // Line vectors: bit 0 = SCL, bit 1 = SDA.
   logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]            filt_q, filt_d, prev_q, prev_d;
   logic [1:0][FCW-1:0]   fcnt_q, fcnt_d;
   logic [1:0]            oe_q, oe_d;
   logic [1:0]            ctrl_q, ctrl_d;
   logic [TIMEOUT_W-1:0]  timeout_q, timeout_d, to_cnt_q, to_cnt_d;
   logic [15:0]           start_cnt_q, start_cnt_d, stop_cnt_q, stop_cnt_d;
   logic                  busy_q, busy_d, stuck_q, stuck_d;
   logic                  ack_q, ack_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic start_ev, stop_ev, line_low, to_en, stuck_set;
   logic wr, rd, sel_ctrl, sel_status, sel_counts, sel_timeout;
   logic unused_data;

   assign unused_data = ^data_i;

   always_comb begin
      sync1_d = {pad_sda_i, pad_scl_i};
      sync2_d = sync1_q;
      prev_d  = filt_q;
      for (int i = 0; i < 2; i++) begin
         filt_d[i] = filt_q[i];
         fcnt_d[i] = '0;
         if (sync2_q[i] != filt_q[i]) begin
            if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
            else                                    fcnt_d[i] = fcnt_q[i] + 1'b1;
         end
      end
   end

   // An SCL edge in the same cycle disqualifies the event because SCL must be high in both cycles.
   assign start_ev = prev_q[0] & filt_q[0] & prev_q[1] & ~filt_q[1];
   assign stop_ev  = prev_q[0] & filt_q[0] & ~prev_q[1] & filt_q[1];

   // Host handshake: each cycle with wren_i or rden_i is acknowledged by a one-cycle ack_o
   // on the next cycle; data_o holds read data only in a read ack and is 0 otherwise.
   // A cycle with both strobes is a write.
   assign wr          = wren_i;
   assign rd          = rden_i & ~wren_i;
   assign sel_ctrl    = (addr_i == ADDR_WIDTH'(0));
   assign sel_status  = (addr_i == ADDR_WIDTH'(1));
   assign sel_counts  = (addr_i == ADDR_WIDTH'(2));
   assign sel_timeout = (addr_i == ADDR_WIDTH'(3));

   assign line_low = ~(filt_q[0] & filt_q[1]);
   assign to_en    = |timeout_q;

   always_comb begin
      to_cnt_d = to_cnt_q;
      if (!line_low)                             to_cnt_d = '0;
      else if (!(to_en && to_cnt_q == timeout_q)) to_cnt_d = to_cnt_q + 1'b1;
   end

   assign stuck_set = line_low & to_en & (to_cnt_d == timeout_q);

   always_comb begin
      stuck_d = stuck_q;
      if (wr && sel_status && data_i[1]) stuck_d = 1'b0;
      if (stuck_set)                     stuck_d = 1'b1;

      busy_d = busy_q;
      if (start_ev)  busy_d = 1'b1;
      if (stop_ev)   busy_d = 1'b0;
      if (stuck_set) busy_d = 1'b0;

      start_cnt_d = start_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      if (start_ev && start_cnt_q != 16'hFFFF) start_cnt_d = start_cnt_q + 16'd1;
      if (stop_ev && stop_cnt_q != 16'hFFFF)   stop_cnt_d  = stop_cnt_q + 16'd1;
      if (wr && sel_counts) begin
         start_cnt_d = '0;
         stop_cnt_d  = '0;
      end

      ctrl_d    = ctrl_q;
      timeout_d = timeout_q;
      if (wr && sel_ctrl)    ctrl_d    = data_i[1:0];
      if (wr && sel_timeout) timeout_d = data_i[TIMEOUT_W-1:0];

      rdata_d = '0;
      if (rd) begin
         if (sel_ctrl)    rdata_d[1:0]           = ctrl_q;
         if (sel_status)  rdata_d[3:0]           = {filt_q[1], filt_q[0], stuck_q, busy_q};
         if (sel_counts)  rdata_d[31:0]          = {stop_cnt_q, start_cnt_q};
         if (sel_timeout) rdata_d[TIMEOUT_W-1:0] = timeout_q;
      end
      ack_d = wren_i | rden_i;

      // Using the next stuck value keeps the pads released in the same cycle stuck_o rises.
      oe_d[0] = ~core_scl_i & ctrl_q[0] & ~ctrl_q[1] & ~stuck_d;
      oe_d[1] = ~core_sda_i & ctrl_q[0] & ~ctrl_q[1] & ~stuck_d;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync1_q     <= 2'b11;
         sync2_q     <= 2'b11;
         filt_q      <= 2'b11;
         prev_q      <= 2'b11;
         fcnt_q      <= '0;
         oe_q        <= 2'b00;
         ctrl_q      <= 2'b01;
         timeout_q   <= '1;
         to_cnt_q    <= '0;
         start_cnt_q <= '0;
         stop_cnt_q  <= '0;
         busy_q      <= 1'b0;
         stuck_q     <= 1'b0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         filt_q      <= filt_d;
         prev_q      <= prev_d;
         fcnt_q      <= fcnt_d;
         oe_q        <= oe_d;
         ctrl_q      <= ctrl_d;
         timeout_q   <= timeout_d;
         to_cnt_q    <= to_cnt_d;
         start_cnt_q <= start_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         busy_q      <= busy_d;
         stuck_q     <= stuck_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
      end
   end

   assign core_scl_o   = filt_q[0];
   assign core_sda_o   = filt_q[1];
   assign pad_scl_oe_o = oe_q[0];
   assign pad_sda_oe_o = oe_q[1];
   assign bus_busy_o   = busy_q;
   assign stuck_o      = stuck_q;
   assign ack_o        = ack_q;
   assign data_o       = rdata_q;

endmodule

// File: tb/tb_twi_line_conditioner.sv
// Directed-plus-random bench for twi_line_conditioner with a behavioural expectation model.
module tb_twi_line_conditioner;

   localparam int FL = 4;

   logic        clk_i, rstn_i;
   logic        pad_scl_i, pad_sda_i, pad_scl_oe_o, pad_sda_oe_o;
   logic        core_scl_o, core_sda_o, core_scl_i, core_sda_i;
   logic        wren_i, rden_i;
   logic [3:0]  addr_i;
   logic [31:0] data_i, data_o;
   logic        ack_o, bus_busy_o, stuck_o;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   int          exp_start, exp_stop;
   logic [31:0] rd_val;

   twi_line_conditioner #(.FILTER_LEN(FL), .TIMEOUT_W(20), .ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .pad_scl_i(pad_scl_i), .pad_sda_i(pad_sda_i),
      .pad_scl_oe_o(pad_scl_oe_o), .pad_sda_oe_o(pad_sda_oe_o),
      .core_scl_o(core_scl_o), .core_sda_o(core_sda_o),
      .core_scl_i(core_scl_i), .core_sda_i(core_sda_i),
      .wren_i(wren_i), .rden_i(rden_i), .addr_i(addr_i), .data_i(data_i),
      .data_o(data_o), .ack_o(ack_o), .bus_busy_o(bus_busy_o), .stuck_o(stuck_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic step(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic host_write(input logic [3:0] a, input logic [31:0] d);
      wren_i = 1'b1; addr_i = a; data_i = d;
      step(1);
      chk("wr_ack", {31'd0, ack_o}, 32'd1);
      chk("wr_data_zero", data_o, 32'd0);
      wren_i = 1'b0;
   endtask

   task automatic host_read(input logic [3:0] a, output logic [31:0] d);
      rden_i = 1'b1; addr_i = a;
      step(1);
      chk("rd_ack", {31'd0, ack_o}, 32'd1);
      d = data_o;
      rden_i = 1'b0;
   endtask

   initial begin
      rstn_i = 1'b0; pad_scl_i = 1'b1; pad_sda_i = 1'b1;
      core_scl_i = 1'b1; core_sda_i = 1'b1;
      wren_i = 1'b0; rden_i = 1'b0; addr_i = '0; data_i = '0;
      exp_start = 0; exp_stop = 0;

      // Reset state
      step(2);
      chk("rst_core_scl", {31'd0, core_scl_o}, 32'd1);
      chk("rst_core_sda", {31'd0, core_sda_o}, 32'd1);
      chk("rst_oe", {30'd0, pad_scl_oe_o, pad_sda_oe_o}, 32'd0);
      chk("rst_ack", {31'd0, ack_o}, 32'd0);
      chk("rst_data", data_o, 32'd0);
      chk("rst_busy_stuck", {30'd0, bus_busy_o, stuck_o}, 32'd0);
      rstn_i = 1'b1;
      step(3);

      host_read(4'd0, rd_val); chk("ctrl_reset", rd_val, 32'h1);
      host_read(4'd3, rd_val); chk("timeout_reset", rd_val, 32'hF_FFFF);
      host_read(4'd2, rd_val); chk("counts_reset", rd_val, 32'h0);
      host_read(4'd1, rd_val); chk("status_idle", rd_val, 32'hC);

      // Glitch filter: a low pulse of w synced cycles propagates iff w >= FL, 2+FL cycles late
      for (int t = 0; t < 8; t++) begin
         int w;
         w = (t == 0) ? 3 : (t == 1) ? 4 : int'($urandom_range(1, 8));
         pad_sda_i = 1'b0;
         for (int j = 0; j < w + 8; j++) begin
            logic exp_sda;
            if (j == w) pad_sda_i = 1'b1;
            step(1);
            exp_sda = (w >= FL && j >= 2 + FL - 1 && j <= w + 2 + FL - 2) ? 1'b0 : 1'b1;
            chk($sformatf("glitch_w%0d_j%0d", w, j), {31'd0, core_sda_o}, {31'd0, exp_sda});
         end
         if (w >= FL) begin
            exp_start++;
            exp_stop++;
         end
         step(4);
      end
      host_read(4'd2, rd_val);
      chk("counts_after_glitch", rd_val, {exp_stop[15:0], exp_start[15:0]});
      host_write(4'd2, 32'hDEAD_BEEF);
      exp_start = 0; exp_stop = 0;

      // START then STOP
      pad_sda_i = 1'b0;
      step(6); chk("busy_before_start", {31'd0, bus_busy_o}, 32'd0);
      step(1); chk("busy_after_start", {31'd0, bus_busy_o}, 32'd1);
      exp_start++;
      pad_sda_i = 1'b1;
      step(6); chk("busy_before_stop", {31'd0, bus_busy_o}, 32'd1);
      step(1); chk("busy_after_stop", {31'd0, bus_busy_o}, 32'd0);
      exp_stop++;
      host_read(4'd2, rd_val); chk("counts_1_1", rd_val, 32'h0001_0001);
      step(1); chk("ack_drops", {31'd0, ack_o}, 32'd0);

      // START, random number of repeated STARTs, STOP
      pad_sda_i = 1'b0; step(8); exp_start++;
      begin
         int n;
         n = int'($urandom_range(2, 4));
         for (int k = 0; k < n; k++) begin
            pad_scl_i = 1'b0; step(8);
            pad_sda_i = 1'b1; step(8);
            pad_scl_i = 1'b1; step(8);
            pad_sda_i = 1'b0; step(8);
            exp_start++;
            chk("busy_rep_start", {31'd0, bus_busy_o}, 32'd1);
         end
      end
      pad_sda_i = 1'b1; step(8); exp_stop++;
      chk("busy_rep_stop", {31'd0, bus_busy_o}, 32'd0);
      host_read(4'd2, rd_val);
      chk("counts_rep", rd_val, {exp_stop[15:0], exp_start[15:0]});

      // Clear write in the same cycle as a START: clear wins
      pad_sda_i = 1'b0;
      step(FL + 2);
      host_write(4'd2, 32'h0);
      exp_start = 0; exp_stop = 0;
      chk("busy_clr_start", {31'd0, bus_busy_o}, 32'd1);
      host_read(4'd2, rd_val); chk("counts_clear_wins", rd_val, 32'h0);
      pad_sda_i = 1'b1; step(8); exp_stop++;
      host_read(4'd2, rd_val); chk("counts_after_stop", rd_val, {exp_stop[15:0], exp_start[15:0]});

      // Pad drive
      core_sda_i = 1'b0;
      step(1);
      chk("oe_sda_on", {31'd0, pad_sda_oe_o}, 32'd1);
      chk("oe_scl_off", {31'd0, pad_scl_oe_o}, 32'd0);
      host_write(4'd0, 32'h0);
      chk("oe_before_ctrl", {31'd0, pad_sda_oe_o}, 32'd1);
      step(1);
      chk("oe_ctrl0", {31'd0, pad_sda_oe_o}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         logic [31:0] v;
         v = $urandom;
         host_write(4'd0, v);
         host_read(4'd0, rd_val);
         chk("ctrl_rand_rd", rd_val, v & 32'h3);
         chk("ctrl_rand_oe", {31'd0, pad_sda_oe_o}, {31'd0, v[0] & ~v[1]});
      end
      host_write(4'd0, 32'h1);
      step(1);
      chk("oe_reenabled", {31'd0, pad_sda_oe_o}, 32'd1);

      // Unmapped addresses
      begin
         logic [3:0] a;
         a = 4'($urandom_range(4, 15));
         host_write(a, $urandom);
         host_read(a, rd_val); chk("unmapped_rd", rd_val, 32'h0);
         host_read(4'd0, rd_val); chk("ctrl_unchanged", rd_val, 32'h1);
         host_read(4'd3, rd_val); chk("timeout_unchanged", rd_val, 32'hF_FFFF);
      end

      // Stuck-low timeout
      begin
         logic [31:0] v;
         v = $urandom;
         host_write(4'd3, v);
         host_read(4'd3, rd_val); chk("timeout_rand_rd", rd_val, v & 32'hF_FFFF);
      end
      host_write(4'd3, 32'd100);
      host_read(4'd3, rd_val); chk("timeout_rd", rd_val, 32'd100);
      pad_scl_i = 1'b0;
      step(FL + 2);
      chk("scl_low_filtered", {31'd0, core_scl_o}, 32'd0);
      step(99);
      chk("stuck_not_yet", {31'd0, stuck_o}, 32'd0);
      chk("oe_before_stuck", {31'd0, pad_sda_oe_o}, 32'd1);
      step(1);
      chk("stuck_set", {31'd0, stuck_o}, 32'd1);
      chk("oe_forced_off", {30'd0, pad_scl_oe_o, pad_sda_oe_o}, 32'd0);
      host_write(4'd1, 32'h2);
      chk("stuck_reasserts", {31'd0, stuck_o}, 32'd1);
      pad_scl_i = 1'b1;
      step(8);
      chk("stuck_sticky", {31'd0, stuck_o}, 32'd1);
      host_write(4'd1, 32'h2);
      chk("stuck_w1c", {31'd0, stuck_o}, 32'd0);
      chk("oe_after_w1c", {31'd0, pad_sda_oe_o}, 32'd1);
      host_read(4'd1, rd_val); chk("status_after_w1c", rd_val, 32'hC);

      // Asynchronous reset mid-transfer
      pad_sda_i = 1'b0;
      step(8);
      chk("busy_pre_reset", {31'd0, bus_busy_o}, 32'd1);
      chk("oe_pre_reset", {31'd0, pad_sda_oe_o}, 32'd1);
      #2 rstn_i = 1'b0;
      #1;
      chk("arst_core", {30'd0, core_scl_o, core_sda_o}, 32'h3);
      chk("arst_oe", {30'd0, pad_scl_oe_o, pad_sda_oe_o}, 32'd0);
      chk("arst_busy_stuck", {30'd0, bus_busy_o, stuck_o}, 32'd0);
      chk("arst_host", {ack_o, data_o[30:0]}, 32'd0);
      pad_sda_i = 1'b1;
      core_sda_i = 1'b1;
      step(2);
      rstn_i = 1'b1;
      step(3);
      host_read(4'd0, rd_val); chk("ctrl_after_arst", rd_val, 32'h1);
      host_read(4'd3, rd_val); chk("timeout_after_arst", rd_val, 32'hF_FFFF);
      host_read(4'd2, rd_val); chk("counts_after_arst", rd_val, 32'h0);
      chk("busy_after_arst", {31'd0, bus_busy_o}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/twi_line_conditioner.md
Name: twi_line_conditioner

Overview:
Pin-side front end for the TWI slave: synchronises and glitch-filters SCL/SDA from the pads before they reach the I2C slave core, and converts the core's release/drive outputs into open-drain pad enables. Detects START/STOP, tracks bus-busy, counts bus events and detects a stuck-low bus, forcing a release when it does. Status and configuration are exposed on the same simple host register bus used by the processor's CFS peripherals.

Parameters:
FILTER_LEN, 4, consecutive stable synchronised cycles required before a filtered line changes (>=1)
TIMEOUT_W, 20, width of the stuck-low timeout counter and limit register (<=32)
ADDR_WIDTH, 4, host word-address width
DATA_WIDTH, 32, host data width

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
pad_scl_i  in  1  raw SCL from pad
pad_sda_i  in  1  raw SDA from pad
pad_scl_oe_o  out  1  1 = drive SCL pad low
pad_sda_oe_o  out  1  1 = drive SDA pad low
core_scl_o  out  1  filtered SCL to I2C slave core
core_sda_o  out  1  filtered SDA to I2C slave core
core_scl_i  in  1  core SCL output, 0 = pull low, 1 = release
core_sda_i  in  1  core SDA output, 0 = pull low, 1 = release
wren_i  in  1  host write strobe
rden_i  in  1  host read strobe
addr_i  in  ADDR_WIDTH  host word address
data_i  in  DATA_WIDTH  host write data
data_o  out  DATA_WIDTH  host read data
ack_o  out  1  host access acknowledge
bus_busy_o  out  1  START seen, STOP not yet seen
stuck_o  out  1  sticky stuck-bus flag

Behaviour:
- Reset values: sync flops, filtered lines, core_scl_o, core_sda_o = 1; pad_*_oe_o = 0; data_o = 0; ack_o = 0; bus_busy_o = 0; stuck_o = 0; counters = 0; CTRL = 0x1; TIMEOUT = all ones.
- Sync: 2-flop synchroniser per line.
- Filter, per line: counter clears whenever synced == filtered; otherwise it increments. At FILTER_LEN, filtered takes the synced value and the counter clears. Pad edge to core_*_o latency = 2 + FILTER_LEN cycles exactly. Pulses shorter than FILTER_LEN synced cycles never propagate.
- Event detection uses the filtered lines and their previous-cycle values.
  - START: SDA 1->0 while SCL = 1 in both cycles.
  - STOP: SDA 0->1 while SCL = 1 in both cycles.
  - Repeated START keeps busy = 1 and increments start_cnt.
  - Busy is set on START and cleared on STOP or when stuck is set.
  - If the SCL and SDA edges fall in the same cycle, no event is generated.
- start_cnt and stop_cnt: 16-bit, saturate at 0xFFFF.
- Timeout counter (TIMEOUT_W bits): increments while either filtered line is 0; clears when both are 1. When the counter == TIMEOUT limit, stuck is set and the counter holds. Limit 0 disables detection.
- Pad drive, registered (1 cycle after core input): pad_x_oe_o = ~core_x_i & CTRL.enable & ~CTRL.force_release & ~stuck.
- Registers, word addresses:
  - 0 CTRL: [0] enable, [1] force_release. R/W.
  - 1 STATUS: [0] busy, [1] stuck (W1C), [2] filtered SCL, [3] filtered SDA. All read-only except stuck.
  - 2 COUNTS: [15:0] start_cnt, [31:16] stop_cnt. Any write clears both.
  - 3 TIMEOUT: [TIMEOUT_W-1:0] limit. R/W.
  - Other addresses read 0; writes are ignored.
  - Unused bits read 0.
- Host handshake:
  - Every wren_i or rden_i cycle produces ack_o = 1 exactly one cycle later.
  - data_o carries read data in the ack cycle only; it is 0 otherwise, including write acks.
  - wren_i and rden_i together: treated as a write.
  - Back-to-back accesses are allowed every cycle.
- Simultaneous events:
  - Stuck set and W1C in the same cycle: set wins.
  - Count increment and clear-write in the same cycle: clear wins.
- Stuck clear does not clear the timeout counter. If a line is still low, stuck re-asserts on the next cycle.
- Asynchronous reset mid-transfer returns all state to reset values immediately. After reset, the bus is assumed idle until a START is seen.

Test Plan:
- FILTER_LEN=4. SDA low pulse of 3 cycles -> core_sda_o stays 1. 4-cycle pulse -> core_sda_o goes 0 exactly 6 cycles after the pad edge.
- START (SDA falls, SCL high), then STOP -> busy 0->1->0. Read addr 2 -> 0x0001_0001, with ack 1 cycle after rden.
- Repeated START x3, then STOP. Write addr 2 in the same cycle as a START -> counts read 0x0000_0000.
- TIMEOUT=100, SCL held low -> stuck_o = 1 after 100 low filtered cycles and pad oes forced 0. Release SCL, write STATUS 0x2 -> stuck_o = 0.
- core_sda_i = 0 with enable = 1 -> pad_sda_oe_o = 1 one cycle later. Write CTRL = 0x0 -> oe drops to 0.
- Reset asserted mid-transfer with busy = 1 and oe = 1 -> all outputs at reset values immediately. CTRL reads 0x1 and TIMEOUT reads 0xFFFFF.
